// File: rtl/ptp_rtc_counter.sv
// ----------------------------------------------------------------------------
// ptp_rtc_counter
//
// PTP real-time clock. Keeps a 48-bit seconds / 30-bit nanoseconds time of day
// plus a 24-bit fractional-ns accumulator, advanced every rtc_clk cycle by a
// programmable increment. Supports an absolute time set, a signed one-shot
// offset adjust, snapshot capture and a pulse-per-second output.
//
// Ports
//   rtc_clk      in   1   sole clock
//   rst_sys      in   1   asynchronous, active-high reset
//   inc_wr_i     in   1   load increment register (effective next cycle)
//   inc_ns_i     in   8   integer ns increment
//   inc_frac_i   in  24   fractional ns increment (units 2^-24 ns)
//   set_wr_i     in   1   absolute time load
//   set_sec_i    in  48   seconds to load
//   set_ns_i     in  30   ns to load, must be < 1e9
//   adj_wr_i     in   1   one-shot offset adjust
//   adj_neg_i    in   1   1 = subtract adj_ns_i
//   adj_ns_i     in  30   offset magnitude, must be < 1e9
//   snap_req_i   in   1   capture request
//   rtc_sec_o    out 48   current seconds
//   rtc_ns_o     out 30   current ns, 0..999_999_999
//   rtc_frac_o   out 24   current fractional ns
//   snap_sec_o   out 48   captured seconds
//   snap_ns_o    out 30   captured ns
//   snap_vld_o   out  1   one-cycle capture strobe
//   pps_o        out  1   seconds-rollover pulse, PPS_W cycles wide
//   err_o        out  1   one-cycle pulse on an out-of-range set or adjust
// ----------------------------------------------------------------------------
module ptp_rtc_counter #(
    parameter int unsigned INC_NS_DEF   = 8,
    parameter logic [23:0] INC_FRAC_DEF = 24'h0,
    parameter int unsigned PPS_W        = 4
) (
    input  logic        rtc_clk,
    input  logic        rst_sys,
    input  logic        inc_wr_i,
    input  logic [7:0]  inc_ns_i,
    input  logic [23:0] inc_frac_i,
    input  logic        set_wr_i,
    input  logic [47:0] set_sec_i,
    input  logic [29:0] set_ns_i,
    input  logic        adj_wr_i,
    input  logic        adj_neg_i,
    input  logic [29:0] adj_ns_i,
    input  logic        snap_req_i,
    output logic [47:0] rtc_sec_o,
    output logic [29:0] rtc_ns_o,
    output logic [23:0] rtc_frac_o,
    output logic [47:0] snap_sec_o,
    output logic [29:0] snap_ns_o,
    output logic        snap_vld_o,
    output logic        pps_o,
    output logic        err_o
);

    localparam logic [29:0]        NS_LIMIT    = 30'd1_000_000_000;
    localparam logic signed [31:0] NS_PER_SEC  = 32'sd1_000_000_000;
    localparam logic [29:0]        NS_WRAP     = 30'd1_000_000_000;

    // State
    logic [7:0]  r_inc_ns;
    logic [23:0] r_inc_frac;
    logic [47:0] r_sec;
    logic [29:0] r_ns;
    logic [23:0] r_frac;
    logic [47:0] r_snap_sec;
    logic [29:0] r_snap_ns;
    logic        r_snap_vld;
    logic        r_err;
    logic [3:0]  r_pps_cnt;

    // Decode of the write strobes
    logic        w_set_ok;
    logic        w_set_bad;
    logic        w_adj_req;
    logic        w_adj_ok;
    logic        w_adj_bad;

    // Datapath
    logic [24:0]        w_frac_sum;
    logic signed [31:0] w_adj_mag;
    logic signed [31:0] w_offset;
    logic signed [31:0] w_sum;
    logic [47:0]        w_next_sec;
    logic [29:0]        w_next_ns;
    logic               w_sec_up;

    assign w_set_ok  = set_wr_i && (set_ns_i < NS_LIMIT);
    assign w_set_bad = set_wr_i && (set_ns_i >= NS_LIMIT);
    // An adjust presented alongside any set is discarded without an error.
    assign w_adj_req = adj_wr_i && !set_wr_i;
    assign w_adj_ok  = w_adj_req && (adj_ns_i < NS_LIMIT);
    assign w_adj_bad = w_adj_req && (adj_ns_i >= NS_LIMIT);

    assign w_frac_sum = {1'b0, r_frac} + {1'b0, r_inc_frac};
    assign w_adj_mag  = $signed({2'b00, adj_ns_i});
    assign w_offset   = !w_adj_ok ? 32'sd0 : (adj_neg_i ? -w_adj_mag : w_adj_mag);

    // Signed 32-bit raw ns; range is roughly -1e9 .. 2e9, well inside 2^31.
    assign w_sum = $signed({2'b00, r_ns})
                 + $signed({24'd0, r_inc_ns})
                 + $signed({31'd0, w_frac_sum[24]})
                 + w_offset;

    // Normalise back into 0..1e9-1. The corrected value fits in 30 bits, so
    // the correction is done modulo 2^30 on the low bits of the raw sum.
    // NOTE: every signal driven here gets a default first so no latch forms.
    always_comb begin
        w_next_sec = r_sec;
        w_next_ns  = w_sum[29:0];
        w_sec_up   = 1'b0;
        if (w_sum >= NS_PER_SEC) begin
            w_next_ns  = w_sum[29:0] - NS_WRAP;
            w_next_sec = r_sec + 48'd1;
            w_sec_up   = 1'b1;
        end else if (w_sum < 32'sd0) begin
            w_next_ns  = w_sum[29:0] + NS_WRAP;
            w_next_sec = r_sec - 48'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values (the snapshot relies on this).
    always_ff @(posedge rtc_clk or posedge rst_sys) begin
        if (rst_sys) begin
            r_inc_ns   <= 8'(INC_NS_DEF);
            r_inc_frac <= INC_FRAC_DEF;
            r_sec      <= '0;
            r_ns       <= '0;
            r_frac     <= '0;
            r_snap_sec <= '0;
            r_snap_ns  <= '0;
            r_snap_vld <= 1'b0;
            r_err      <= 1'b0;
            r_pps_cnt  <= '0;
        end else begin
            if (inc_wr_i) begin
                r_inc_ns   <= inc_ns_i;
                r_inc_frac <= inc_frac_i;
            end

            if (w_set_ok) begin
                r_sec  <= set_sec_i;
                r_ns   <= set_ns_i;
                r_frac <= '0;
            end else begin
                r_sec  <= w_next_sec;
                r_ns   <= w_next_ns;
                r_frac <= w_frac_sum[23:0];
            end

            // Only a forward rollover (re)starts the pulse; a new one while
            // active reloads the counter and stretches the pulse.
            if (!w_set_ok && w_sec_up) begin
                r_pps_cnt <= 4'(PPS_W);
            end else if (r_pps_cnt != 4'd0) begin
                r_pps_cnt <= r_pps_cnt - 4'd1;
            end

            r_err      <= w_set_bad || w_adj_bad;
            r_snap_vld <= snap_req_i;
            if (snap_req_i) begin
                r_snap_sec <= r_sec;
                r_snap_ns  <= r_ns;
            end
        end
    end

    assign rtc_sec_o  = r_sec;
    assign rtc_ns_o   = r_ns;
    assign rtc_frac_o = r_frac;
    assign snap_sec_o = r_snap_sec;
    assign snap_ns_o  = r_snap_ns;
    assign snap_vld_o = r_snap_vld;
    assign pps_o      = (r_pps_cnt != 4'd0);
    assign err_o      = r_err;

endmodule

// File: tb/tb_ptp_rtc_counter.sv
// ----------------------------------------------------------------------------
// tb_ptp_rtc_counter
//
// Directed bench for ptp_rtc_counter. Each step pushes the values the DUT must
// show after the next rtc_clk edge onto a scoreboard queue; the queue is
// drained and compared 1 ns after that edge.
// ----------------------------------------------------------------------------
module tb_ptp_rtc_counter;

    logic        rtc_clk = 1'b0;
    logic        rst_sys = 1'b1;
    logic        inc_wr_i = 1'b0;
    logic [7:0]  inc_ns_i = '0;
    logic [23:0] inc_frac_i = '0;
    logic        set_wr_i = 1'b0;
    logic [47:0] set_sec_i = '0;
    logic [29:0] set_ns_i = '0;
    logic        adj_wr_i = 1'b0;
    logic        adj_neg_i = 1'b0;
    logic [29:0] adj_ns_i = '0;
    logic        snap_req_i = 1'b0;
    logic [47:0] rtc_sec_o;
    logic [29:0] rtc_ns_o;
    logic [23:0] rtc_frac_o;
    logic [47:0] snap_sec_o;
    logic [29:0] snap_ns_o;
    logic        snap_vld_o;
    logic        pps_o;
    logic        err_o;

    always #4 rtc_clk = ~rtc_clk;

    ptp_rtc_counter #(
        .INC_NS_DEF   (8),
        .INC_FRAC_DEF (24'h0),
        .PPS_W        (4)
    ) dut (
        .rtc_clk    (rtc_clk),
        .rst_sys    (rst_sys),
        .inc_wr_i   (inc_wr_i),
        .inc_ns_i   (inc_ns_i),
        .inc_frac_i (inc_frac_i),
        .set_wr_i   (set_wr_i),
        .set_sec_i  (set_sec_i),
        .set_ns_i   (set_ns_i),
        .adj_wr_i   (adj_wr_i),
        .adj_neg_i  (adj_neg_i),
        .adj_ns_i   (adj_ns_i),
        .snap_req_i (snap_req_i),
        .rtc_sec_o  (rtc_sec_o),
        .rtc_ns_o   (rtc_ns_o),
        .rtc_frac_o (rtc_frac_o),
        .snap_sec_o (snap_sec_o),
        .snap_ns_o  (snap_ns_o),
        .snap_vld_o (snap_vld_o),
        .pps_o      (pps_o),
        .err_o      (err_o)
    );

    typedef enum int {O_SEC, O_NS, O_FRAC, O_PPS, O_ERR, O_SVLD, O_SSEC, O_SNS} obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [47:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_eval = 0;
    int   n_fail = 0;

    function automatic logic [47:0] observe(obs_e sel);
        case (sel)
            O_SEC:   return rtc_sec_o;
            O_NS:    return 48'(rtc_ns_o);
            O_FRAC:  return 48'(rtc_frac_o);
            O_PPS:   return 48'(pps_o);
            O_ERR:   return 48'(err_o);
            O_SVLD:  return 48'(snap_vld_o);
            O_SSEC:  return snap_sec_o;
            O_SNS:   return 48'(snap_ns_o);
            default: return 'x;
        endcase
    endfunction

    task automatic exp_v(input string tag, input obs_e sel, input logic [47:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_time(input string tag, input logic [47:0] s, input logic [29:0] n);
        exp_v({tag, ".sec"}, O_SEC, s);
        exp_v({tag, ".ns"}, O_NS, 48'(n));
    endtask

    task automatic exp_bit(input string tag, input obs_e sel, input logic b);
        exp_v(tag, sel, 48'(b));
    endtask

    task automatic check_all();
        exp_t        e;
        logic [47:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_eval++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one edge, then compare everything queued for it.
    task automatic tick();
        @(posedge rtc_clk);
        #1;
        check_all();
    endtask

    task automatic clear_strobes();
        inc_wr_i   = 1'b0;
        set_wr_i   = 1'b0;
        adj_wr_i   = 1'b0;
        adj_neg_i  = 1'b0;
        snap_req_i = 1'b0;
    endtask

    task automatic drive_set(input logic [47:0] s, input logic [29:0] n);
        set_wr_i  = 1'b1;
        set_sec_i = s;
        set_ns_i  = n;
    endtask

    task automatic drive_adj(input logic neg, input logic [29:0] n);
        adj_wr_i  = 1'b1;
        adj_neg_i = neg;
        adj_ns_i  = n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (2) @(posedge rtc_clk);
        #1;
        exp_time("rst", 48'd0, 30'd0);
        exp_v("rst.frac", O_FRAC, 48'd0);
        exp_bit("rst.pps", O_PPS, 1'b0);
        exp_bit("rst.err", O_ERR, 1'b0);
        exp_bit("rst.svld", O_SVLD, 1'b0);
        exp_v("rst.ssec", O_SSEC, 48'd0);
        exp_v("rst.sns", O_SNS, 48'd0);
        check_all();
        rst_sys = 1'b0;
        exp_time("first_inc", 48'd0, 30'd8);
        tick();

        // ---- set near rollover, PPS width ----
        drive_set(48'd5, 30'd999_999_992);
        exp_time("set5", 48'd5, 30'd999_999_992);
        exp_v("set5.frac", O_FRAC, 48'd0);
        exp_bit("set5.pps", O_PPS, 1'b0);
        tick();
        clear_strobes();
        exp_time("roll6", 48'd6, 30'd0);
        exp_bit("roll6.pps", O_PPS, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_bit("pps.hold", O_PPS, 1'b1);
            tick();
        end
        exp_bit("pps.end", O_PPS, 1'b0);
        exp_time("pps.end", 48'd6, 30'd32);
        tick();

        // ---- negative adjust across a second boundary ----
        drive_set(48'd10, 30'd100);
        exp_time("set10", 48'd10, 30'd100);
        tick();
        clear_strobes();
        drive_adj(1'b1, 30'd200);
        exp_time("adj-200", 48'd9, 30'd999_999_908);
        exp_bit("adj-200.pps", O_PPS, 1'b0);
        exp_bit("adj-200.err", O_ERR, 1'b0);
        tick();
        clear_strobes();
        exp_time("after_adj", 48'd9, 30'd999_999_916);
        tick();

        // ---- positive adjust across a second boundary ----
        drive_set(48'd3, 30'd999_999_000);
        exp_time("set3", 48'd3, 30'd999_999_000);
        tick();
        clear_strobes();
        drive_adj(1'b0, 30'd1000);
        exp_time("adj+1000", 48'd4, 30'd8);
        exp_bit("adj+1000.pps", O_PPS, 1'b1);
        tick();
        clear_strobes();

        // ---- seconds wrap downward and upward ----
        drive_set(48'd0, 30'd5);
        tick();
        clear_strobes();
        drive_adj(1'b1, 30'd100);
        exp_time("wrap_down", 48'hFFFF_FFFF_FFFF, 30'd999_999_913);
        tick();
        clear_strobes();
        drive_set(48'hFFFF_FFFF_FFFF, 30'd999_999_992);
        tick();
        clear_strobes();
        exp_time("wrap_up", 48'd0, 30'd0);
        exp_bit("wrap_up.pps", O_PPS, 1'b1);
        tick();

        // ---- out-of-range adjust ----
        drive_adj(1'b0, 30'd1_000_000_000);
        exp_time("bad_adj", 48'd0, 30'd8);
        exp_bit("bad_adj.err", O_ERR, 1'b1);
        tick();
        clear_strobes();
        exp_bit("bad_adj.err_clr", O_ERR, 1'b0);
        exp_v("bad_adj.ns2", O_NS, 48'd16);
        tick();

        // ---- set and adjust together, then bad set ----
        drive_set(48'd1, 30'd500);
        drive_adj(1'b0, 30'd1000);
        exp_time("set+adj", 48'd1, 30'd500);
        exp_bit("set+adj.err", O_ERR, 1'b0);
        tick();
        clear_strobes();
        drive_set(48'd77, 30'd1_000_000_000);
        exp_time("bad_set", 48'd1, 30'd508);
        exp_bit("bad_set.err", O_ERR, 1'b1);
        tick();
        clear_strobes();
        exp_bit("bad_set.err_clr", O_ERR, 1'b0);
        exp_v("bad_set.ns2", O_NS, 48'd516);
        tick();

        // ---- fractional increment (XGE) ----
        inc_wr_i   = 1'b1;
        inc_ns_i   = 8'd6;
        inc_frac_i = 24'h666667;
        tick();
        clear_strobes();
        drive_set(48'd0, 30'd0);
        exp_time("xge.set", 48'd0, 30'd0);
        exp_v("xge.set.frac", O_FRAC, 48'd0);
        tick();
        clear_strobes();
        tick();
        tick();
        exp_v("xge.c3.ns", O_NS, 48'd19);
        exp_v("xge.c3.frac", O_FRAC, 48'h333335);
        tick();
        tick();
        exp_time("xge.c5", 48'd0, 30'd32);
        exp_v("xge.c5.frac", O_FRAC, 48'h000003);
        tick();

        // ---- snapshots, back to back ----
        inc_wr_i   = 1'b1;
        inc_ns_i   = 8'd8;
        inc_frac_i = 24'h0;
        drive_set(48'd2, 30'd1000);
        exp_time("snap.set", 48'd2, 30'd1000);
        exp_bit("snap.idle", O_SVLD, 1'b0);
        tick();
        clear_strobes();
        snap_req_i = 1'b1;
        exp_bit("snap1.vld", O_SVLD, 1'b1);
        exp_v("snap1.sec", O_SSEC, 48'd2);
        exp_v("snap1.ns", O_SNS, 48'd1000);
        exp_v("snap1.live", O_NS, 48'd1008);
        tick();
        exp_bit("snap2.vld", O_SVLD, 1'b1);
        exp_v("snap2.ns", O_SNS, 48'd1008);
        tick();
        exp_bit("snap3.vld", O_SVLD, 1'b1);
        exp_v("snap3.ns", O_SNS, 48'd1016);
        exp_v("snap3.live", O_NS, 48'd1024);
        tick();
        snap_req_i = 1'b0;
        exp_bit("snap.off", O_SVLD, 1'b0);
        exp_v("snap.hold", O_SNS, 48'd1016);
        tick();

        // ---- asynchronous reset during a PPS pulse ----
        drive_set(48'd5, 30'd999_999_992);
        tick();
        clear_strobes();
        exp_bit("pre_rst.pps", O_PPS, 1'b1);
        tick();
        exp_bit("pre_rst.pps2", O_PPS, 1'b1);
        tick();
        #2;
        rst_sys = 1'b1;
        #1;
        exp_bit("async_rst.pps", O_PPS, 1'b0);
        exp_time("async_rst", 48'd0, 30'd0);
        exp_v("async_rst.frac", O_FRAC, 48'd0);
        exp_v("async_rst.ssec", O_SSEC, 48'd0);
        check_all();
        exp_v("in_rst.ns", O_NS, 48'd0);
        tick();
        rst_sys = 1'b0;
        exp_v("resume.ns8", O_NS, 48'd8);
        tick();
        exp_time("resume.ns16", 48'd0, 30'd16);
        exp_bit("resume.pps", O_PPS, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
